// File: rtl/alu_op_sequencer.sv
// rtl/alu_op_sequencer.sv - command-side sequencer for the combinational ALU
//
// Accepts one operation per cmd_valid/cmd_ready handshake, registers it onto
// the ALU inputs, waits SETTLE_CYCLES edges, captures the ALU result and flags,
// and presents them on a rsp_valid/rsp_ready channel.
//
// Ports:
//   clk, rst                  rising-edge clock, asynchronous active-high reset
//   cmd_valid/cmd_ready       command handshake
//   cmd_op, cmd_a, cmd_b      op (00 add, 01 sub, 10 and, 11 or) and operands
//   alu_a, alu_b, alu_control registered ALU inputs, change only on accept
//   alu_result, alu_flags     ALU outputs, flags [3]N [2]Z [1]C [0]V
//   rsp_valid/rsp_ready       response handshake
//   rsp_result, rsp_flags     captured ALU outputs, held while rsp_valid
//   clr_sticky, sticky_v      sticky arithmetic overflow and its clear
//   op_count                  completed responses, modulo 256
//
// SETTLE_CYCLES must be in 1..15; the settle counter is 4 bits wide.

module alu_op_sequencer #(
  parameter int BITS          = 5,
  parameter int SETTLE_CYCLES = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            cmd_valid,
  output logic            cmd_ready,
  input  logic [1:0]      cmd_op,
  input  logic [BITS-1:0] cmd_a,
  input  logic [BITS-1:0] cmd_b,
  output logic [BITS-1:0] alu_a,
  output logic [BITS-1:0] alu_b,
  output logic [1:0]      alu_control,
  input  logic [BITS-1:0] alu_result,
  input  logic [3:0]      alu_flags,
  output logic            rsp_valid,
  input  logic            rsp_ready,
  output logic [BITS-1:0] rsp_result,
  output logic [3:0]      rsp_flags,
  input  logic            clr_sticky,
  output logic            sticky_v,
  output logic [7:0]      op_count
);

  typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_t;

  localparam logic [3:0] SETTLE_LAST = 4'(SETTLE_CYCLES - 1);

  state_t     state;
  logic [3:0] settle_cnt;
  logic       capture;
  logic       set_v;

  assign capture = (state == ISSUE) && (settle_cnt == SETTLE_LAST);
  // Only add/sub (alu_control[1]=0) may raise the sticky overflow.
  assign set_v   = capture && !alu_control[1] && alu_flags[0];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      cmd_ready   <= 1'b1;
      alu_a       <= '0;
      alu_b       <= '0;
      alu_control <= '0;
      settle_cnt  <= '0;
      rsp_valid   <= 1'b0;
      rsp_result  <= '0;
      rsp_flags   <= '0;
      sticky_v    <= 1'b0;
      op_count    <= '0;
    end else begin
      // Set has priority over clear when both land on the same edge.
      if (set_v) begin
        sticky_v <= 1'b1;
      end else if (clr_sticky) begin
        sticky_v <= 1'b0;
      end

      case (state)
        IDLE: begin
          if (cmd_valid) begin
            alu_a       <= cmd_a;
            alu_b       <= cmd_b;
            alu_control <= cmd_op;
            settle_cnt  <= '0;
            cmd_ready   <= 1'b0;
            state       <= ISSUE;
          end
        end
        ISSUE: begin
          settle_cnt <= settle_cnt + 4'd1;
          if (capture) begin
            rsp_result <= alu_result;
            rsp_flags  <= alu_flags;
            rsp_valid  <= 1'b1;
            state      <= RESP;
          end
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            cmd_ready <= 1'b1;
            op_count  <= op_count + 8'd1;
            state     <= IDLE;
          end
        end
        default: begin
          state     <= IDLE;
          cmd_ready <= 1'b1;
          rsp_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_op_sequencer.sv
// tb/tb_alu_op_sequencer.sv - directed table-driven bench for alu_op_sequencer

module tb_alu_op_sequencer;

  localparam int BITS = 5;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            cmd_valid = 1'b0;
  logic            cmd_ready;
  logic [1:0]      cmd_op = '0;
  logic [BITS-1:0] cmd_a = '0;
  logic [BITS-1:0] cmd_b = '0;
  logic [BITS-1:0] alu_a;
  logic [BITS-1:0] alu_b;
  logic [1:0]      alu_control;
  logic [BITS-1:0] alu_result;
  logic [3:0]      alu_flags;
  logic            rsp_valid;
  logic            rsp_ready = 1'b1;
  logic [BITS-1:0] rsp_result;
  logic [3:0]      rsp_flags;
  logic            clr_sticky = 1'b0;
  logic            sticky_v;
  logic [7:0]      op_count;

  logic            force_v = 1'b0;

  alu_op_sequencer #(.BITS(BITS), .SETTLE_CYCLES(1)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_a(cmd_a), .cmd_b(cmd_b),
    .alu_a(alu_a), .alu_b(alu_b), .alu_control(alu_control),
    .alu_result(alu_result), .alu_flags(alu_flags),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_result(rsp_result), .rsp_flags(rsp_flags),
    .clr_sticky(clr_sticky), .sticky_v(sticky_v), .op_count(op_count)
  );

  always #5 clk = ~clk;

  // Behavioural ALU: standard N/Z/C/V, C is carry-out for add, no-borrow for sub.
  logic [BITS:0] wide;
  logic          alu_c;
  logic          alu_v;
  always_comb begin
    wide       = '0;
    alu_result = '0;
    alu_c      = 1'b0;
    alu_v      = 1'b0;
    case (alu_control)
      2'b00: begin
        wide       = {1'b0, alu_a} + {1'b0, alu_b};
        alu_result = wide[BITS-1:0];
        alu_c      = wide[BITS];
        alu_v      = (alu_a[BITS-1] == alu_b[BITS-1]) && (alu_result[BITS-1] != alu_a[BITS-1]);
      end
      2'b01: begin
        wide       = {1'b0, alu_a} - {1'b0, alu_b};
        alu_result = wide[BITS-1:0];
        alu_c      = ~wide[BITS];
        alu_v      = (alu_a[BITS-1] != alu_b[BITS-1]) && (alu_result[BITS-1] != alu_a[BITS-1]);
      end
      2'b10:   alu_result = alu_a & alu_b;
      default: alu_result = alu_a | alu_b;
    endcase
    if (force_v) alu_v = 1'b1;
    alu_flags = {alu_result[BITS-1], (alu_result == '0), alu_c, alu_v};
  end

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Issue one op with rsp_ready high; returns edges from accept to rsp_valid,
  // the response seen, sticky at capture, and rsp_valid after the handshake edge.
  task automatic run_op(input logic [1:0] op, input logic [4:0] a, input logic [4:0] b,
                        output int lat, output logic [4:0] r, output logic [3:0] f,
                        output logic s, output logic rv_after);
    int n;
    n = 0;
    while (!cmd_ready && n < 20) begin step(); n++; end
    if (!cmd_ready) chk("cmd_ready_timeout", 0, 1);
    rsp_ready = 1'b1;
    cmd_op = op; cmd_a = a; cmd_b = b; cmd_valid = 1'b1;
    step();
    cmd_valid = 1'b0;
    lat = 0;
    while (!rsp_valid && lat < 40) begin step(); lat++; end
    if (!rsp_valid) chk("rsp_valid_timeout", 0, 1);
    r = rsp_result; f = rsp_flags; s = sticky_v;
    step();
    rv_after = rsp_valid;
  endtask

  typedef struct {
    logic [1:0] op;
    logic [4:0] a;
    logic [4:0] b;
    logic       fv;
    logic       clr_before;
    logic [4:0] res;
    logic [3:0] flags;
    logic       sticky;
  } vec_t;

  vec_t vecs[6];

  initial begin
    int lat;
    int n;
    logic [4:0] r;
    logic [3:0] f;
    logic s;
    logic rv;
    logic [7:0] exp_cnt;

    //            op     a         b         fv  clr  res       NZCV     sticky
    vecs[0] = '{2'b00, 5'd7,     5'd9,     0,  0,  5'b10000, 4'b1001, 1};
    vecs[1] = '{2'b01, 5'd5,     5'd5,     0,  0,  5'b00000, 4'b0110, 1};
    vecs[2] = '{2'b10, 5'b10110, 5'b01111, 1,  1,  5'b00110, 4'b0001, 0};
    vecs[3] = '{2'b11, 5'b10000, 5'b00001, 0,  0,  5'b10001, 4'b1000, 0};
    vecs[4] = '{2'b01, 5'b10000, 5'b00001, 0,  0,  5'b01111, 4'b0011, 1};
    vecs[5] = '{2'b00, 5'b11111, 5'b00001, 0,  1,  5'b00000, 4'b0110, 0};

    // Reset state
    #2;
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_alu_a", alu_a, 0);
    chk("rst_alu_control", alu_control, 0);
    chk("rst_rsp_result", rsp_result, 0);
    chk("rst_sticky", sticky_v, 0);
    chk("rst_op_count", op_count, 0);
    step(); step();
    rst = 1'b0;
    step();
    chk("rst_cmd_ready", cmd_ready, 1);

    // Table-driven ops
    exp_cnt = 8'd0;
    for (int i = 0; i < 6; i++) begin
      if (vecs[i].clr_before) begin
        clr_sticky = 1'b1; step(); clr_sticky = 1'b0;
      end
      force_v = vecs[i].fv;
      run_op(vecs[i].op, vecs[i].a, vecs[i].b, lat, r, f, s, rv);
      force_v = 1'b0;
      exp_cnt++;
      chk($sformatf("v%0d_latency", i), lat, 1);
      chk($sformatf("v%0d_result", i), r, vecs[i].res);
      chk($sformatf("v%0d_flags", i), f, vecs[i].flags);
      chk($sformatf("v%0d_sticky", i), s, vecs[i].sticky);
      chk($sformatf("v%0d_rsp_drop", i), rv, 0);
      chk($sformatf("v%0d_op_count", i), op_count, exp_cnt);
    end

    // Back-pressure: 3+4 held in RESP while a new command is offered
    rsp_ready = 1'b0;
    cmd_op = 2'b00; cmd_a = 5'd3; cmd_b = 5'd4; cmd_valid = 1'b1;
    step();
    cmd_a = 5'd1; cmd_b = 5'd1; cmd_op = 2'b01;
    n = 0;
    while (!rsp_valid && n < 20) begin step(); n++; end
    chk("bp_rsp_valid", rsp_valid, 1);
    for (int k = 0; k < 5; k++) begin
      step();
      chk("bp_hold_valid", rsp_valid, 1);
      chk("bp_hold_result", rsp_result, 5'd7);
      chk("bp_hold_flags", rsp_flags, 4'b0000);
      chk("bp_cmd_ready", cmd_ready, 0);
      chk("bp_alu_a", alu_a, 5'd3);
      chk("bp_alu_b", alu_b, 5'd4);
    end
    cmd_valid = 1'b0;
    rsp_ready = 1'b1;
    step();
    exp_cnt++;
    chk("bp_release_drop", rsp_valid, 0);
    chk("bp_op_count", op_count, exp_cnt);
    step(); step();
    chk("bp_no_second_rsp", rsp_valid, 0);
    chk("bp_not_queued", alu_a, 5'd3);
    chk("bp_count_stable", op_count, exp_cnt);

    // Clear and overflow capture on the same edge: set wins
    clr_sticky = 1'b1; step(); clr_sticky = 1'b0;
    chk("clr_pre", sticky_v, 0);
    cmd_op = 2'b00; cmd_a = 5'd7; cmd_b = 5'd9; cmd_valid = 1'b1;
    step();
    cmd_valid = 1'b0;
    clr_sticky = 1'b1;
    step();
    clr_sticky = 1'b0;
    chk("same_edge_valid", rsp_valid, 1);
    chk("same_edge_set_wins", sticky_v, 1);
    step();
    exp_cnt++;
    clr_sticky = 1'b1; step(); clr_sticky = 1'b0;
    chk("clr_alone", sticky_v, 0);
    chk("clr_op_count", op_count, exp_cnt);

    // Reset during ISSUE
    cmd_op = 2'b00; cmd_a = 5'd15; cmd_b = 5'd15; cmd_valid = 1'b1;
    step();
    cmd_valid = 1'b0;
    chk("mid_in_issue", alu_a, 5'd15);
    rst = 1'b1;
    #1;
    chk("mid_rst_valid", rsp_valid, 0);
    chk("mid_rst_alu_a", alu_a, 0);
    chk("mid_rst_alu_b", alu_b, 0);
    chk("mid_rst_sticky", sticky_v, 0);
    chk("mid_rst_op_count", op_count, 0);
    step(); step();
    rst = 1'b0;
    step();
    chk("mid_cmd_ready", cmd_ready, 1);
    for (int k = 0; k < 4; k++) begin
      step();
      chk("mid_no_rsp", rsp_valid, 0);
    end
    chk("mid_op_count", op_count, 0);

    // 256 completed ops wrap op_count
    for (int k = 0; k < 255; k++) run_op(2'b10, 5'd0, 5'd0, lat, r, f, s, rv);
    chk("wrap_255", op_count, 8'd255);
    run_op(2'b10, 5'd0, 5'd0, lat, r, f, s, rv);
    chk("wrap_0", op_count, 8'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
